mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MA stage between execution and register writeback. Takes ld/st/writeback commands from EX
//  and drives a single-outstanding data-memory request/ack bus: byte enables, store lane
//  replication, load lane extraction with sign/zero extension. Emits a 1-cycle writeback
//  pulse to the register file and holds EX via stall_ma while a bus access is open.
// PARAMETERS
//  ACK_TIMEOUT  255  max cycles dmem_req may wait for dmem_ack; 0 = no timeout
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset; one clock, reset is synchronous and active-high
//  cmd_ld_ma      in   1   load command, 1-cycle pulse
//  cmd_st_ma      in   1   store command, 1-cycle pulse
//  wbk_rd_reg_ma  in   1   instruction writes rd
//  rd_adr_ma      in   5   destination register
//  rd_data_ma     in   32  ALU result; effective address for ld/st
//  st_data_ma     in   32  store data (rs2)
//  ldst_code_ma   in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  dmem_req       out  1   bus request
//  dmem_we        out  1   1 = write
//  dmem_adr       out  30  word address [31:2]
//  dmem_be        out  4   byte enables
//  dmem_wdata     out  32  write data
//  dmem_ack       in   1   access complete; dmem_rdata valid in the same cycle
//  dmem_rdata     in   32  read data
//  stall_ma       out  1   hold EX; no new command accepted
//  wbk_rd_reg_wb  out  1   register-file write strobe, 1 cycle
//  rd_adr_wb      out  5   writeback register
//  rd_data_wb     out  32  writeback data
//  misalign_exc   out  1   1-cycle pulse: misaligned or illegal-width access
//  bus_err        out  1   1-cycle pulse: ack timeout
//  fault_adr      out  32  address of last misalign/bus_err; held until next fault
//  overrun_err    out  1   sticky: command arrived while busy
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0, every output 0. Mid-access reset drops dmem_req at
//    the same edge; the pending access produces no writeback.
//  - FSM IDLE/BUS. Inputs are sampled only in IDLE, in the cycle any cmd_* or wbk_rd_reg_ma is 1.
//  - stall_ma = (state==BUS) | (IDLE & (cmd_ld_ma|cmd_st_ma) & access legal); combinational.
//  - ALU op (wbk only, no ld/st): next cycle wbk_rd_reg_wb=1, rd_data_wb=rd_data_ma. Latency 1.
//  - cmd_ld_ma & cmd_st_ma both 1: the load executes; the store is dropped and overrun_err is set.
//  - Legality: code 011/110/111, H with adr[0]=1, or W with adr[1:0]!=0 -> no bus cycle, no
//    writeback. Next cycle misalign_exc=1, fault_adr=adr. Stores may use codes 000/001/010 only.
//  - Legal ld/st: BUS entered next cycle with dmem_req=1. adr/be/wdata/we are registered and held
//    stable until ack. Timeout counter cleared on entry.
//  - Store: SB be=4'b0001<<adr[1:0], wdata={4{st[7:0]}}; SH be=adr[1]?1100:0011,
//    wdata={2{st[15:0]}}; SW be=1111.
//  - Load: be set as for the store case. Lane = adr[1:0] (B) or adr[1] (H). Sign-extend for
//    000/001; zero-extend for 100/101.
//  - dmem_ack in BUS: dmem_req falls next cycle and state returns to IDLE. For a load,
//    wbk_rd_reg_wb=1 with the extracted data in the cycle after ack (so ack -> wb = 1 cycle).
//    For a store, no writeback.
//  - Timeout: counter increments each BUS cycle without ack. When it reaches ACK_TIMEOUT, drop
//    req, return to IDLE, pulse bus_err, fault_adr=adr, no writeback. Ack on the same cycle wins.
//  - rd_adr==0: wbk_rd_reg_wb forced 0; the load bus cycle still runs.
//  - A command in BUS, or in the cycle the result emerges, is ignored and sets overrun_err.
//  - dmem_ack outside BUS is ignored.
// TESTING
//  - ALU wb: wbk=1, rd=5, data=0x1234 -> next cycle wb=1, rd_adr_wb=5, rd_data_wb=0x1234; no req.
//  - LB adr=0x103, ack after 3 cycles, rdata=0x80FF_FF00 -> be=1000, stall 4 cycles,
//    rd_data_wb=0xFFFF_FF80; LBU gives 0x0000_0080.
//  - SH adr=0x202, st=0xAAAA_BEEF -> dmem_adr=0x80, be=1100, wdata=0xBEEF_BEEF, we=1, no wb.
//  - LW adr=0x101 -> no req, misalign_exc pulse, fault_adr=0x101, no wb; code 011 -> same result.
//  - ACK_TIMEOUT=4, no ack -> req high 4 cycles, then bus_err pulse and IDLE; rst mid-BUS ->
//    req=0 next edge.
//  - cmd_st_ma during BUS -> overrun_err=1 stays until rst; the original access completes
//    normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns EX ld/st/wb commands into single-outstanding dmem bus cycles and RF writebacks.
// Latency: ALU writeback 1 cycle; load writeback 1 cycle after dmem_ack; exceptions pulse 1 cycle after command.
// Backpressure: stall_ma holds EX while a bus access is open; commands arriving while busy are dropped and flag overrun_err.
module mem_access_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_ld_ma,
    input  logic        cmd_st_ma,
    input  logic        wbk_rd_reg_ma,
    input  logic [4:0]  rd_adr_ma,
    input  logic [31:0] rd_data_ma,
    input  logic [31:0] st_data_ma,
    input  logic [2:0]  ldst_code_ma,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_adr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_ma,
    output logic        wbk_rd_reg_wb,
    output logic [4:0]  rd_adr_wb,
    output logic [31:0] rd_data_wb,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic [31:0] fault_adr,
    output logic        overrun_err
);
    localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    typedef enum logic {S_IDLE = 1'b0, S_BUS = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d, we_q, we_d;
    logic [29:0]       adr_q, adr_d;
    logic [1:0]        lo_q, lo_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        code_q, code_d;
    logic [4:0]        rd_q, rd_d;
    logic              wbk_q, wbk_d;
    logic              wb_q, wb_d;
    logic [4:0]        rd_wb_q, rd_wb_d;
    logic [31:0]       data_wb_q, data_wb_d;
    logic              mis_q, mis_d, berr_q, berr_d;
    logic [31:0]       fault_q, fault_d;
    logic              ovr_q, ovr_d;
    logic              ld_done_q, ld_done_d;

    logic              is_ldst, cmd_any, code_ok, align_ok, legal, accept, tmo_hit;
    logic [3:0]        be_calc;
    logic [31:0]       wdata_calc, ld_val;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [CNT_W-1:0]  cnt_inc;

    // Decode the incoming command: legality, byte enables and replicated store data
    always_comb begin
        is_ldst    = cmd_ld_ma | cmd_st_ma;
        cmd_any    = is_ldst | wbk_rd_reg_ma;
        code_ok    = 1'b0;
        align_ok   = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = st_data_ma;
        case (ldst_code_ma)
            3'b000, 3'b001, 3'b010: code_ok = 1'b1;
            3'b100, 3'b101:         code_ok = cmd_ld_ma;   // unsigned widths exist for loads only
            default:                code_ok = 1'b0;
        endcase
        case (ldst_code_ma[1:0])
            2'b00: begin
                align_ok   = 1'b1;
                be_calc    = 4'b0001 << rd_data_ma[1:0];
                wdata_calc = {4{st_data_ma[7:0]}};
            end
            2'b01: begin
                align_ok   = ~rd_data_ma[0];
                be_calc    = rd_data_ma[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{st_data_ma[15:0]}};
            end
            2'b10:   align_ok = (rd_data_ma[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
        legal = code_ok & align_ok;
    end

    // Select the addressed lane of the read data and extend it to 32 bits
    always_comb begin
        ld_half = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lo_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        case (code_q[1:0])
            2'b00:   ld_val = code_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = code_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_val = dmem_rdata;
        endcase
    end

    assign stall_ma = (state_q == S_BUS) | ((state_q == S_IDLE) & is_ldst & legal);
    // The cycle a load result leaves the stage is still busy for new commands
    assign accept   = (state_q == S_IDLE) & ~ld_done_q;
    assign cnt_inc  = cnt_q + 1'b1;
    assign tmo_hit  = (ACK_TIMEOUT != 0) && (cnt_inc == CNT_W'(ACK_TIMEOUT));

    // Next-state: command acceptance in IDLE, ack/timeout handling in BUS
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        adr_d     = adr_q;
        lo_d      = lo_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        code_d    = code_q;
        rd_d      = rd_q;
        wbk_d     = wbk_q;
        wb_d      = 1'b0;
        rd_wb_d   = rd_wb_q;
        data_wb_d = data_wb_q;
        mis_d     = 1'b0;
        berr_d    = 1'b0;
        fault_d   = fault_q;
        ld_done_d = 1'b0;
        // Sticky: command while busy, or a store colliding with a load
        ovr_d     = ovr_q | (cmd_any & ~accept) | (accept & cmd_ld_ma & cmd_st_ma);
        case (state_q)
            S_IDLE: begin
                if (accept && cmd_any) begin
                    if (is_ldst) begin
                        if (legal) begin
                            state_d = S_BUS;
                            cnt_d   = '0;
                            req_d   = 1'b1;
                            we_d    = ~cmd_ld_ma;
                            adr_d   = rd_data_ma[31:2];
                            lo_d    = rd_data_ma[1:0];
                            be_d    = be_calc;
                            wdata_d = wdata_calc;
                            code_d  = ldst_code_ma;
                            rd_d    = rd_adr_ma;
                            wbk_d   = wbk_rd_reg_ma;
                        end else begin
                            mis_d   = 1'b1;
                            fault_d = rd_data_ma;
                        end
                    end else begin
                        wb_d      = (rd_adr_ma != 5'd0);
                        rd_wb_d   = rd_adr_ma;
                        data_wb_d = rd_data_ma;
                    end
                end
            end
            S_BUS: begin
                if (dmem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        wb_d      = wbk_q & (rd_q != 5'd0);
                        rd_wb_d   = rd_q;
                        data_wb_d = ld_val;
                        ld_done_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    fault_d = {adr_q, lo_q};
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything including an open access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            lo_q      <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            code_q    <= '0;
            rd_q      <= '0;
            wbk_q     <= 1'b0;
            wb_q      <= 1'b0;
            rd_wb_q   <= '0;
            data_wb_q <= '0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
            fault_q   <= '0;
            ovr_q     <= 1'b0;
            ld_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            lo_q      <= lo_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            code_q    <= code_d;
            rd_q      <= rd_d;
            wbk_q     <= wbk_d;
            wb_q      <= wb_d;
            rd_wb_q   <= rd_wb_d;
            data_wb_q <= data_wb_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
            fault_q   <= fault_d;
            ovr_q     <= ovr_d;
            ld_done_q <= ld_done_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_adr      = adr_q;
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;
    assign wbk_rd_reg_wb = wb_q;
    assign rd_adr_wb     = rd_wb_q;
    assign rd_data_wb    = data_wb_q;
    assign misalign_exc  = mis_q;
    assign bus_err       = berr_q;
    assign fault_adr     = fault_q;
    assign overrun_err   = ovr_q;
endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma;
    logic [4:0]  rd_adr_ma;
    logic [31:0] rd_data_ma, st_data_ma;
    logic [2:0]  ldst_code_ma;
    logic        dmem_req, dmem_we;
    logic [29:0] dmem_adr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_ma, wbk_rd_reg_wb;
    logic [4:0]  rd_adr_wb;
    logic [31:0] rd_data_wb;
    logic        misalign_exc, bus_err;
    logic [31:0] fault_adr;
    logic        overrun_err;

    mem_access_stage #(.ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma), .wbk_rd_reg_ma(wbk_rd_reg_ma),
        .rd_adr_ma(rd_adr_ma), .rd_data_ma(rd_data_ma), .st_data_ma(st_data_ma),
        .ldst_code_ma(ldst_code_ma),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_adr(dmem_adr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_ma(stall_ma), .wbk_rd_reg_wb(wbk_rd_reg_wb), .rd_adr_wb(rd_adr_wb),
        .rd_data_wb(rd_data_wb), .misalign_exc(misalign_exc), .bus_err(bus_err),
        .fault_adr(fault_adr), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    // One command: inputs plus the bus cycle on which the bench acks (0 = never)
    typedef struct {
        logic        ld, st, wbk;
        logic [4:0]  rd;
        logic [31:0] adr, sd;
        logic [2:0]  code;
        int          k;
        logic [31:0] rdata;
    } stim_t;

    // What is seen on the outputs over the whole transaction window
    typedef struct {
        int          req_n;
        logic        we;
        logic [29:0] adrw;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        unstable;
        int          wb_n;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        int          mis_n, berr_n, stall_n;
    } obs_t;

    typedef struct { stim_t s; obs_t e; } vec_t;

    int tests = 0;
    int fails = 0;
    logic [31:0] fault_m;
    logic        ovr_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic stim_t S(logic ld, logic st, logic wbk, logic [4:0] rd, logic [31:0] adr,
                                logic [31:0] sd, logic [2:0] code, int k, logic [31:0] rdata);
        stim_t s;
        s.ld = ld; s.st = st; s.wbk = wbk; s.rd = rd; s.adr = adr; s.sd = sd;
        s.code = code; s.k = k; s.rdata = rdata;
        return s;
    endfunction

    function automatic obs_t E(int req_n, logic we, logic [29:0] adrw, logic [3:0] be,
                               logic [31:0] wdata, int wb_n, logic [4:0] wb_rd, logic [31:0] wb_data,
                               int mis_n, int berr_n, int stall_n);
        obs_t e;
        e.req_n = req_n; e.we = we; e.adrw = adrw; e.be = be; e.wdata = wdata; e.unstable = 1'b0;
        e.wb_n = wb_n; e.wb_rd = wb_rd; e.wb_data = wb_data;
        e.mis_n = mis_n; e.berr_n = berr_n; e.stall_n = stall_n;
        return e;
    endfunction

    // Reference model: derives the whole transaction outcome from the rules with plain arithmetic
    function automatic obs_t model(stim_t s);
        obs_t e;
        int w, lane;
        bit ok, acked;
        logic [31:0] v;
        e = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (s.ld || s.st) begin
            case (s.code)
                3'd0, 3'd4: w = 1;
                3'd1, 3'd5: w = 2;
                3'd2:       w = 4;
                default:    w = 0;
            endcase
            ok = (w != 0) && (s.ld || s.code < 4) && ((s.adr % w) == 0);
            if (!ok) begin
                e.mis_n = 1;
                return e;
            end
            lane   = int'(s.adr % 4);
            e.we   = !s.ld;
            e.adrw = s.adr[31:2];
            e.be   = 4'(((1 << w) - 1) << lane);
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = s.sd[8*(i % w) +: 8];
            acked     = (s.k >= 1) && (s.k <= TMO);
            e.req_n   = acked ? s.k : TMO;
            e.berr_n  = acked ? 0 : 1;
            e.stall_n = 1 + e.req_n;
            if (s.ld && acked && s.wbk && s.rd != 0) begin
                v = s.rdata >> (8 * lane);
                if (w == 1) v = (s.code[2] || !v[7])  ? (v & 32'hFF)   : (v | 32'hFFFF_FF00);
                if (w == 2) v = (s.code[2] || !v[15]) ? (v & 32'hFFFF) : (v | 32'hFFFF_0000);
                e.wb_n = 1; e.wb_rd = s.rd; e.wb_data = v;
            end
        end else if (s.wbk && s.rd != 0) begin
            e.wb_n = 1; e.wb_rd = s.rd; e.wb_data = s.adr;
        end
        return e;
    endfunction

    task automatic clear_cmd();
        cmd_ld_ma = 0; cmd_st_ma = 0; wbk_rd_reg_ma = 0;
        rd_adr_ma = 0; rd_data_ma = 0; st_data_ma = 0; ldst_code_ma = 0;
    endtask

    // Issue one command, play the memory side, and record everything seen for 10 cycles
    task automatic run_txn(input stim_t s, output obs_t o);
        int bus_n = 0;
        o = E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        cmd_ld_ma = s.ld; cmd_st_ma = s.st; wbk_rd_reg_ma = s.wbk; rd_adr_ma = s.rd;
        rd_data_ma = s.adr; st_data_ma = s.sd; ldst_code_ma = s.code;
        #1 if (stall_ma) o.stall_n++;
        @(negedge clk);
        clear_cmd();
        for (int c = 0; c < 10; c++) begin
            if (dmem_req) begin
                bus_n++;
                o.req_n++;
                if (o.req_n == 1) begin
                    o.we = dmem_we; o.adrw = dmem_adr; o.be = dmem_be; o.wdata = dmem_wdata;
                end else if (o.we !== dmem_we || o.adrw !== dmem_adr || o.be !== dmem_be ||
                             o.wdata !== dmem_wdata) begin
                    o.unstable = 1'b1;
                end
            end
            if (stall_ma) o.stall_n++;
            if (wbk_rd_reg_wb) begin
                o.wb_n++; o.wb_rd = rd_adr_wb; o.wb_data = rd_data_wb;
            end
            if (misalign_exc) o.mis_n++;
            if (bus_err) o.berr_n++;
            dmem_ack   = dmem_req && (bus_n == s.k);
            dmem_rdata = dmem_ack ? s.rdata : $urandom;
            @(negedge clk);
        end
        dmem_ack = 0;
    endtask

    task automatic cmp_obs(input string t, input stim_t s, input obs_t a, input obs_t e);
        chk({t, "_req_cycles"}, a.req_n, e.req_n);
        if (e.req_n > 0) begin
            chk({t, "_we"}, a.we, e.we);
            chk({t, "_adr"}, a.adrw, e.adrw);
            chk({t, "_be"}, a.be, e.be);
            chk({t, "_stable"}, a.unstable, 0);
            if (e.we) chk({t, "_wdata"}, a.wdata, e.wdata);
        end
        chk({t, "_wb_count"}, a.wb_n, e.wb_n);
        if (e.wb_n > 0) begin
            chk({t, "_wb_rd"}, a.wb_rd, e.wb_rd);
            chk({t, "_wb_data"}, a.wb_data, e.wb_data);
        end
        chk({t, "_misalign"}, a.mis_n, e.mis_n);
        chk({t, "_bus_err"}, a.berr_n, e.berr_n);
        chk({t, "_stall"}, a.stall_n, e.stall_n);
        if (e.mis_n > 0 || e.berr_n > 0) fault_m = s.adr;
        if (s.ld && s.st) ovr_m = 1'b1;
        chk({t, "_fault_adr"}, fault_adr, fault_m);
        chk({t, "_overrun"}, overrun_err, ovr_m);
    endtask

    function automatic logic all_outs_zero();
        return ({dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata, stall_ma, wbk_rd_reg_wb,
                 rd_adr_wb, rd_data_wb, misalign_exc, bus_err, fault_adr, overrun_err} == '0);
    endfunction

    initial begin
        vec_t  vecs[$];
        obs_t  o;
        stim_t s;
        int    wbn, reqn;

        rst = 1; dmem_ack = 0; dmem_rdata = 0;
        clear_cmd();
        fault_m = 0; ovr_m = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("reset_outputs_zero", all_outs_zero(), 1);

        // Directed vectors with hand-derived expectations
        vecs.push_back('{S(0,0,1,5,32'h1234,0,3'b000,0,0),             E(0,0,0,0,0,1,5,32'h1234,0,0,0)});
        vecs.push_back('{S(1,0,1,3,32'h103,0,3'b000,3,32'h80FF_FF00),  E(3,0,30'h40,4'b1000,0,1,3,32'hFFFF_FF80,0,0,4)});
        vecs.push_back('{S(1,0,1,3,32'h103,0,3'b100,3,32'h80FF_FF00),  E(3,0,30'h40,4'b1000,0,1,3,32'h0000_0080,0,0,4)});
        vecs.push_back('{S(0,1,0,0,32'h202,32'hAAAA_BEEF,3'b001,1,0),  E(1,1,30'h80,4'b1100,32'hBEEF_BEEF,0,0,0,0,0,2)});
        vecs.push_back('{S(1,0,1,4,32'h101,0,3'b010,1,0),              E(0,0,0,0,0,0,0,0,1,0,0)});
        vecs.push_back('{S(1,0,1,4,32'h100,0,3'b011,1,0),              E(0,0,0,0,0,0,0,0,1,0,0)});
        vecs.push_back('{S(1,0,1,6,32'h104,0,3'b010,0,32'h1111_1111),  E(4,0,30'h41,4'b1111,0,0,0,0,0,1,5)});
        vecs.push_back('{S(1,0,1,8,32'h102,0,3'b001,1,32'h8001_1234),  E(1,0,30'h40,4'b1100,0,1,8,32'hFFFF_8001,0,0,2)});
        vecs.push_back('{S(1,0,1,9,32'h100,0,3'b101,2,32'h1234_F00D),  E(2,0,30'h40,4'b0011,0,1,9,32'h0000_F00D,0,0,3)});
        vecs.push_back('{S(1,0,1,0,32'h101,0,3'b000,2,32'h0000_AB00),  E(2,0,30'h40,4'b0010,0,0,0,0,0,0,3)});
        vecs.push_back('{S(0,1,0,0,32'h12,32'h55,3'b000,1,0),          E(1,1,30'h4,4'b0100,32'h5555_5555,0,0,0,0,0,2)});
        vecs.push_back('{S(0,1,0,0,32'h14,32'h55,3'b100,1,0),          E(0,0,0,0,0,0,0,0,1,0,0)});
        vecs.push_back('{S(0,1,0,0,32'h8,32'hDEAD_BEEF,3'b010,4,0),    E(4,1,30'h2,4'b1111,32'hDEAD_BEEF,0,0,0,0,0,5)});
        vecs.push_back('{S(1,0,1,2,32'h10C,0,3'b010,5,32'h1),          E(4,0,30'h43,4'b1111,0,0,0,0,0,1,5)});
        vecs.push_back('{S(0,0,1,0,32'h77,0,3'b000,0,0),               E(0,0,0,0,0,0,0,0,0,0,0)});
        vecs.push_back('{S(1,0,1,1,32'h103,0,3'b101,1,0),              E(0,0,0,0,0,0,0,0,1,0,0)});
        foreach (vecs[i]) begin
            run_txn(vecs[i].s, o);
            cmp_obs($sformatf("vec%0d", i), vecs[i].s, o, vecs[i].e);
        end

        // Store arriving mid-access: ignored, sticky overrun, load still completes
        @(negedge clk);
        cmd_ld_ma = 1; wbk_rd_reg_ma = 1; rd_adr_ma = 7; rd_data_ma = 32'h40; ldst_code_ma = 3'b010;
        @(negedge clk);
        clear_cmd();
        chk("ovr_req_first", dmem_req, 1);
        cmd_st_ma = 1; st_data_ma = 32'h1234_5678; rd_data_ma = 32'h80;
        @(negedge clk);
        clear_cmd();
        chk("ovr_req_held", dmem_req, 1);
        chk("ovr_adr_held", dmem_adr, 30'h10);
        chk("ovr_we_held", dmem_we, 0);
        chk("ovr_flag_set", overrun_err, 1);
        dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_ack = 0;
        chk("ovr_wb_strobe", wbk_rd_reg_wb, 1);
        chk("ovr_wb_data", rd_data_wb, 32'hCAFE_F00D);
        chk("ovr_wb_rd", rd_adr_wb, 7);
        @(negedge clk);
        chk("ovr_store_dropped", dmem_req, 0);
        chk("ovr_flag_sticky", overrun_err, 1);
        ovr_m = 1'b1;

        // Randomized commands against the reference model
        for (int n = 0; n < 250; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            s = S(kind == 9 || (kind >= 2 && kind <= 5), kind >= 6, $urandom_range(0, 7) != 0,
                  5'($urandom), 32'($urandom_range(0, 1023)), $urandom, 3'b000,
                  $urandom_range(0, 6), $urandom);
            if (kind <= 1) s.adr = $urandom;
            case ($urandom_range(0, 5))
                0:       s.code = 3'($urandom);
                1, 2:    s.code = 3'b010;
                3:       s.code = 3'b001 | (s.ld ? {$urandom_range(0, 1) == 1, 2'b00} : 3'b000);
                default: s.code = 3'b000 | (s.ld ? {$urandom_range(0, 1) == 1, 2'b00} : 3'b000);
            endcase
            run_txn(s, o);
            cmp_obs($sformatf("rnd%0d", n), s, o, model(s));
        end

        // Reset in the middle of an access
        @(negedge clk);
        cmd_ld_ma = 1; wbk_rd_reg_ma = 1; rd_adr_ma = 3; rd_data_ma = 32'h200; ldst_code_ma = 3'b010;
        @(negedge clk);
        clear_cmd();
        @(negedge clk);
        chk("rst_mid_req_before", dmem_req, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid_req_drop", dmem_req, 0);
        chk("rst_mid_stall_drop", stall_ma, 0);
        wbn = 0; reqn = 0;
        dmem_ack = 1; dmem_rdata = 32'h5A5A_5A5A;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (wbk_rd_reg_wb) wbn++;
            if (dmem_req) reqn++;
        end
        dmem_ack = 0;
        chk("rst_mid_no_wb", wbn, 0);
        chk("rst_mid_no_req", reqn, 0);
        chk("rst_mid_outputs_zero", all_outs_zero(), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
